// File: rtl/cp0_exc.sv
// Coprocessor-0 exception/interrupt controller beside the M stage.
// Decides entry each cycle, maintains SR/Cause/EPC, and serves mfc0/mtc0.
module cp0_exc #(
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic [5:0]  exccode_m,
  input  logic        bd_m,
  input  logic [5:0]  hwint,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        cp0_we,
  input  logic        eret_m,
  output logic [31:0] cp0_rdata,
  output logic        exc_req,
  output logic [31:0] exc_pc,
  output logic [31:0] epc_out,
  output logic        exl
);

  localparam int unsigned IM_W   = 6;
  localparam int unsigned CODE_W = 5;

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [IM_W-1:0]   sr_im;
  logic              sr_exl;
  logic              sr_ie;
  logic              cause_bd;
  logic [IM_W-1:0]   cause_ip;
  logic [CODE_W-1:0] cause_code;
  logic [31:0]       epc;

  logic              int_pend;
  logic              exc_pend;

  // Entry decision: interrupts and exceptions are both masked by EXL.
  always_comb begin
    int_pend = (|(hwint & sr_im)) & sr_ie & ~sr_exl;
    exc_pend = (exccode_m != 6'd0) & ~sr_exl;
    exc_req  = int_pend | exc_pend;
  end

  // mfc0 read port: registered contents, unmapped numbers read as zero.
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
      ADDR_CAUSE: cp0_rdata = {cause_bd, 15'd0, cause_ip, 3'd0, cause_code, 2'd0};
      ADDR_EPC:   cp0_rdata = epc;
      ADDR_PRID:  cp0_rdata = PRID_VAL;
      default:    cp0_rdata = 32'd0;
    endcase
  end

  assign exc_pc  = EXC_ENTRY;
  assign epc_out = epc;
  assign exl     = sr_exl;

  // CP0 state: entry has precedence over the flushed mtc0/eret in M.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im      <= '0;
      sr_exl     <= 1'b0;
      sr_ie      <= 1'b0;
      cause_bd   <= 1'b0;
      cause_ip   <= '0;
      cause_code <= '0;
      epc        <= 32'd0;
    end else begin
      cause_ip <= hwint;
      if (exc_req) begin
        sr_exl     <= 1'b1;
        cause_bd   <= bd_m;
        cause_code <= int_pend ? CODE_W'(0) : exccode_m[CODE_W-1:0];
        epc        <= bd_m ? (pc_m - 32'd4) : pc_m;
      end else begin
        if (cp0_we) begin
          case (cp0_addr)
            ADDR_SR: begin
              sr_im  <= cp0_wdata[15:10];
              sr_exl <= cp0_wdata[1];
              sr_ie  <= cp0_wdata[0];
            end
            ADDR_EPC: epc <= cp0_wdata;
            default: ;
          endcase
        end
        if (eret_m) sr_exl <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cp0_exc.md
# cp0_exc

Coprocessor-0 exception and interrupt controller: the consumer of the exception code, branch-delay flag and PC that the pipeline's per-stage exception detectors produce and carry down to the memory stage. Each cycle it decides whether to take an exception or interrupt. On entry it updates SR, Cause and EPC, and it clears the exception level on `eret`. It also services `mfc0`/`mtc0` accesses, and sits beside the M stage, driving the flush and redirect controls of the pipeline.

## Interface
- `EXC_ENTRY`, 32'h0000_4180, handler address driven on `exc_pc`
- `PRID_VAL`, 32'h0000_0000, constant value of PRId (reg 15)
- `clk` input 1, rising-edge clock
- `reset` input 1, asynchronous, active-low; clears all state while low
- `pc_m` input 32, PC of the instruction in M
- `exccode_m` input 6, accumulated exception code of the M instruction; 0 = none, 4 = AdEL, etc.
- `bd_m` input 1, M instruction sits in a branch delay slot
- `hwint` input 6, external interrupt lines, level-sensitive
- `cp0_addr` input 5, register number for `mfc0`/`mtc0`
- `cp0_wdata` input 32, `mtc0` data
- `cp0_we` input 1, `mtc0` in M
- `eret_m` input 1, `eret` in M
- `cp0_rdata` output 32, combinational read of `cp0_addr`
- `exc_req` output 1, take exception or interrupt this cycle (flush and redirect)
- `exc_pc` output 32, constant `EXC_ENTRY`
- `epc_out` output 32, current EPC register (target of `eret`)
- `exl` output 1, SR.EXL

## Operation
- Registers:
  - SR (12): IM = bits 15:10, EXL = bit 1, IE = bit 0; other bits read 0.
  - Cause (13): BD = bit 31, IP = bits 15:10, ExcCode = bits 6:2; other bits read 0.
  - EPC (14): 32 bits.
  - PRId (15): returns `PRID_VAL`.
- Interrupt and exception conditions:
  - `int_pend = |(hwint & SR.IM) & SR.IE & !SR.EXL`
  - `exc_pend = (exccode_m != 0) & !SR.EXL`
  - `exc_req = int_pend | exc_pend`. Interrupt has priority over an exception.
- On `exc_req` at the clock edge:
  - EXL <= 1.
  - Cause.BD <= `bd_m`.
  - Cause.ExcCode <= 0 if `int_pend`, else `exccode_m[4:0]`.
  - EPC <= `bd_m` ? `pc_m - 4` : `pc_m`. No alignment masking, so a faulting PC is preserved.
- Cause.IP <= `hwint` on every edge, unconditionally.
- `mtc0` (`cp0_we` & !`exc_req`):
  - addr 12 writes IM, EXL and IE only.
  - addr 14 writes all 32 bits of EPC.
  - addr 13, 15 and all others: ignored.
- `mtc0` in the same cycle as `exc_req` is discarded (the instruction is flushed).
- `eret_m` & !`exc_req`: EXL <= 0. `eret` with EXL already 0 leaves EXL at 0.
- `cp0_rdata`: value of the addressed register before the edge. Unmapped addresses return 0. Cause.IP reads the registered sample, not live `hwint`.

## Timing
- Reset (`reset` = 0, asynchronous): SR, Cause and EPC = 0. Therefore `exl` = 0, `epc_out` = 0, `exc_req` = 0 (IE = 0 and `exccode_m` is assumed 0 by the bench during reset). `exc_pc` is always `EXC_ENTRY`.
- `exc_req` and `cp0_rdata` are combinational, with zero latency from their inputs.
- Register updates become visible one cycle after the edge. `epc_out` reflects an `mtc0` to EPC on the cycle after the write; there is no internal bypass (the forwarding unit handles it).
- While EXL = 1, neither interrupts nor exceptions are taken; `exccode_m` is ignored. The exception nesting depth is therefore 1.
- Simultaneous `exc_req` and `eret_m`: the entry wins and EXL stays 1. This can only occur when EXL = 0.
- Reset deasserted mid-cycle: state is released at the deassertion. The first entry can occur at the first subsequent edge.

## Test plan
- **Reset:** hold `reset` = 0 with random inputs -> all outputs 0 except `exc_pc` = 32'h4180; `cp0_rdata` for address 15 returns `PRID_VAL`.
- **AdEL outside delay slot:**
  - Stimulus: `pc_m` = 32'h0000_2ffc, `exccode_m` = 4, `bd_m` = 0.
  - Required: `exc_req` = 1. Next cycle EPC = 32'h2ffc, Cause.ExcCode = 4, BD = 0, EXL = 1.
  - A repeat of the same stimulus yields `exc_req` = 0.
- **AdEL in delay slot:** `pc_m` = 32'h0000_3008, `bd_m` = 1, `exccode_m` = 4 -> EPC = 32'h3004, Cause = 32'h8000_0010.
- **Interrupt over exception:**
  - Stimulus: `mtc0` SR = 32'h0000_fc01, then `hwint` = 6'b000100 with `exccode_m` = 4.
  - Required: `exc_req` = 1, Cause.ExcCode = 0, Cause.IP = 6'b000100.
  - With IE = 0 instead: `exc_req` is driven only by the exception.
- **eret and mtc0 edges:**
  - `eret_m` with EXL = 1 -> EXL = 0 next cycle.
  - `mtc0` to address 13 with 32'hffff_ffff -> Cause unchanged.
  - `mtc0` to address 14 in the same cycle as `exc_req` -> EPC = the exception PC, not the written data.
- **Asynchronous reset mid-handler:** EXL = 1 and EPC = 32'h3010, then `reset` pulses low between edges -> outputs clear immediately, without waiting for `clk`.
